// File: rtl/shake_squeeze.sv
// SHAKE squeeze stage: streams the rate lanes of a Keccak state as 64-bit words and requests
// further permutations until out_len words are delivered. Define SHAKE_SQZ_BSWAP_EN to byte-swap dout.
module shake_squeeze #(
    parameter int unsigned RATE_LANES = 21,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       out_len,
    input  logic [4:0][4:0][63:0]  state_in,
    output logic                   perm_req,
    input  logic                   perm_done,
    output logic [63:0]            dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned IDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

    typedef enum logic [1:0] {StIdle, StEmit, StPerm, StFin} state_t;

    state_t                       state_q, state_d;
    logic [LEN_W-1:0]             remaining_q, remaining_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [RATE_LANES-1:0][63:0]  lane_buf_q;
    logic [RATE_LANES-1:0][63:0]  rate_lanes;
    logic                         load;
    logic [63:0]                  lane;
    logic [63:0]                  dout_lane;
    logic                         unused_state;

    // Lane i of the rate portion is A[i % 5][i / 5].
    for (genvar i = 0; i < RATE_LANES; i++) begin : g_rate
        assign rate_lanes[i] = state_in[i % 5][i / 5];
    end

    // Capacity lanes are never output.
    assign unused_state = ^state_in;

    assign lane = lane_buf_q[idx_q];

`ifdef SHAKE_SQZ_BSWAP_EN
    for (genvar b = 0; b < 8; b++) begin : g_bswap
        assign dout_lane[8*(7-b) +: 8] = lane[8*b +: 8];
    end
`else
    assign dout_lane = lane;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        load        = 1'b0;
        perm_req    = 1'b0;
        dout_valid  = 1'b0;
        dout        = '0;
        busy        = (state_q != StIdle);
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (out_len != '0) begin
                        load        = 1'b1;
                        remaining_d = out_len;
                        idx_d       = '0;
                        state_d     = StEmit;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StEmit: begin
                dout_valid = 1'b1;
                dout       = dout_lane;
                if (dout_ready) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StFin;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = StPerm;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StPerm: begin
                perm_req = 1'b1;
                if (perm_done) begin
                    load    = 1'b1;
                    state_d = StEmit;
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            idx_q       <= '0;
            lane_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            if (load) begin
                lane_buf_q <= rate_lanes;
            end
        end
    end

endmodule

// File: doc/shake_squeeze.md
Name: shake_squeeze

Overview:
- Output (squeeze) end of the SHAKE sponge; complements the absorb/permutation path that writes the 5x5x64 Keccak state.
- Takes the permuted state and streams its rate lanes out as 64-bit words over a valid/ready interface.
- When the rate is exhausted and more output is required, requests another Keccak-f permutation from the core and resumes on the new state.

Parameters:
RATE_LANES, 21, lanes per squeeze block (21 = SHAKE128, 17 = SHAKE256); legal range 1..25
LEN_W, 16, width of the requested output length (in 64-bit words)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  pulse; begin squeeze; state_in valid this cycle
out_len  input  LEN_W  number of 64-bit words to emit; sampled on start
state_in  input  64 x [4:0][4:0]  Keccak state, indexed [x][y], bit z = lane bit z
perm_req  output  1  level; request a permutation of the core state
perm_done  input  1  pulse; permutation finished, state_in holds the new state
dout  output  64  output lane
dout_valid  output  1  dout holds a valid word
dout_ready  input  1  sink accepts dout
busy  output  1  high from accepted start until the done pulse, inclusive
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset values: perm_req=0, dout=0, dout_valid=0, busy=0, done=0. FSM=IDLE; internal lane buffer, lane index and word counter cleared.
- Lane order: index i = x + 5*y, for i = 0..RATE_LANES-1. Word i = A[i%5][i/5]. Lane bit 0 appears on dout[0] (little-endian Keccak byte order).
- FSM states: IDLE, EMIT, PERM, FIN.
- IDLE:
  - start with out_len != 0: capture the RATE_LANES lanes of state_in into the internal buffer, set remaining=out_len, set lane index=0, set busy=1, go to EMIT.
  - start with out_len == 0: go to FIN; no words are emitted.
- EMIT:
  - dout_valid=1 and dout=buffer[lane index], registered.
  - Latency: first dout_valid appears the cycle after start.
  - A handshake (valid & ready) decrements remaining and increments the lane index.
  - With dout_ready held high, one word is emitted per cycle.
  - dout and dout_valid are stable while valid & !ready.
  - If the handshake takes remaining to 0: go to FIN and drop dout_valid next cycle.
  - Else if the lane index reaches RATE_LANES: go to PERM, drop dout_valid, reset the lane index to 0.
- PERM:
  - perm_req=1, held until perm_done.
  - On perm_done: capture state_in into the buffer, deassert perm_req, go to EMIT; dout_valid rises the next cycle.
  - perm_done may arrive in the first PERM cycle.
- FIN: done=1 for exactly one cycle, busy=0 in the following cycle, return to IDLE.
- start while not in IDLE is ignored; out_len and state_in are not resampled.
- perm_done outside PERM is ignored.
- Total words emitted = out_len exactly. Permutation requests = ceil(out_len/RATE_LANES) - 1.
- The remaining counter is LEN_W bits and never wraps: out_len = 2^LEN_W - 1 is legal.
- rst asserted mid-operation: return to reset values immediately, drop any in-flight word, deassert perm_req.

Optional Feature:
- Macro: SHAKE_SQZ_BSWAP_EN.
- Defined: dout is each lane byte-reversed (buffer byte 0 on dout[63:56]) for big-endian sinks. Timing and handshake are unchanged.
- Undefined: dout = lane unchanged (bit z on dout[z]).

Test Plan:
- state_in A[x][y] = {x,y} pattern (lane = 64'h0000_0000_0000_00yx), RATE_LANES=21, start with out_len=3, dout_ready=1 -> words 64'h00, 64'h01, 64'h02 on 3 consecutive cycles starting cycle+1; done pulses after the third; perm_req never asserts.
- out_len=21, ready high -> 21 words in lane order ending with A[0][4] (0x40); no perm_req; done once.
- out_len=25 -> perm_req rises after word 21; perm_done delayed 5 cycles with the state changed to all-ones -> words 22..25 = 64'hFFFF_FFFF_FFFF_FFFF; exactly one perm_req episode.
- Backpressure: dout_ready toggled 1,0,0,1 -> dout stays stable across the stalls; no word is lost or duplicated; count = out_len.
- start with out_len=0 -> no dout_valid; done pulses one cycle later; busy high for exactly 1 cycle.
- rst asserted during PERM with out_len=40 -> perm_req, dout_valid, busy at 0 immediately. Restart with out_len=2 -> words = new lanes 0..1.
